// File: rtl/bullet_fire_ctrl.sv
// Bullet fire controller: button sync/debounce, trigger pulse, movement strobe, shot sequencing.
// Optional macro AUTOFIRE_EN: a held button re-fires on every return to IDLE.
module bullet_fire_ctrl #(
  parameter int DEB_CYCLES     = 20000,
  parameter int TICK_DIV       = 250000,
  parameter int FLIGHT_TICKS   = 220,
  parameter int COOLDOWN_TICKS = 50,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_fire,
  input  logic       face_right,
  output logic       trigger,
  output logic       timer,
  output logic       d,
  output logic       busy,
  output logic [1:0] state_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FIRE     = 2'd1;
  localparam logic [1:0] FLIGHT   = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);

  logic             sync_1, btn_s, btn_db, btn_db_q;
  logic [CNT_W-1:0] deb_cnt, pre_cnt, tick_cnt;
  logic [1:0]       state;
  logic             fire_req, start;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync_1   <= btn_fire;
      btn_s    <= sync_1;
      btn_db_q <= btn_db;
      if (btn_s != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign fire_req = btn_db & ~btn_db_q;

`ifdef AUTOFIRE_EN
  // Level-sensitive start: a button still held when IDLE is reached fires again.
  assign start = fire_req | btn_db;
`else
  assign start = fire_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      timer   <= 1'b0;
    end else begin
      timer   <= (pre_cnt == TICK_LAST);
      pre_cnt <= (pre_cnt == TICK_LAST) ? '0 : pre_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      d        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FIRE;
            d     <= face_right;
          end
        end
        FIRE: begin
          tick_cnt <= '0;
          state    <= FLIGHT;
        end
        FLIGHT: begin
          if (timer) begin
            if (tick_cnt == FLIGHT_LAST) begin
              tick_cnt <= '0;
              state    <= COOLDOWN;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (COOLDOWN_TICKS == 0) begin
            state <= IDLE;
          end else if (timer) begin
            if (tick_cnt == COOL_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign trigger = (state == FIRE);
  assign busy    = (state != IDLE);
  assign state_o = state;

endmodule
